// File: rtl/b2c_req_arbiter_pkg.sv
// Shared types and defaults for the blockB-to-blockC request arbiter family.
package b2c_req_arbiter_pkg;

  localparam int unsigned B2C_TIMEOUT_DFLT = 255;
  localparam int unsigned B2C_MAX_REQ      = 8;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } b2c_state_t;

  typedef logic [$clog2(B2C_MAX_REQ)-1:0] grant_idx_t;

endpackage

// File: rtl/b2c_req_arbiter_rr.sv
// Combinational round-robin pick: first asserted request after rr_ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req_vec,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       any_req
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  logic        found;
  int unsigned cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    // Offsets 1..NUM_REQ visit every requester once, the last pick last.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_vec[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = IW'(cand);
      end
    end
    any_req = |req_vec;
  end

endmodule

// File: rtl/b2c_req_arbiter.sv
// Round-robin arbiter sharing the blockB-to-blockC req/ack channel between rdy/vld producers.
module b2c_req_arbiter
  import b2c_req_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = B2C_TIMEOUT_DFLT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          in_vld,
  input  logic [NUM_REQ*DATA_W-1:0]   in_data,
  output logic [NUM_REQ-1:0]          in_rdy,
  output logic                        req,
  output logic [DATA_W-1:0]           req_data,
  input  logic                        ack,
  input  logic                        arb_en,
  input  logic                        err_clr,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic [15:0]                 done_cnt,
  output logic                        timeout_err
);

  localparam int unsigned GW    = $clog2(NUM_REQ);
  localparam int unsigned TW    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int unsigned TLAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  b2c_state_t          state, state_nxt;
  logic [GW-1:0]       rr_ptr;
  logic [TW-1:0]       tcnt;
  logic [NUM_REQ-1:0]  pick_gnt;
  logic [GW-1:0]       pick_idx;
  logic                pick_any;
  logic [DATA_W-1:0]   pick_data;
  logic                accept;
  logic                tmo_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_vec (in_vld),
    .rr_ptr  (rr_ptr),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any_req (pick_any)
  );

  always_comb begin
    pick_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) pick_data = in_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    tmo_hit = (TIMEOUT_CYC != 0) && (tcnt == TW'(TLAST));
  end

  always_comb begin
    state_nxt = state;
    in_rdy    = '0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (arb_en && pick_any) begin
          accept    = 1'b1;
          in_rdy    = pick_gnt;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (ack || tmo_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req  = (state == REQ);
  assign busy = (state == REQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_data    <= '0;
      grant_id    <= '0;
      rr_ptr      <= GW'(NUM_REQ - 1);
      tcnt        <= '0;
      done_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_data <= pick_data;
        grant_id <= pick_idx;
        tcnt     <= '0;
      end
      if (state == REQ) begin
        // ack takes precedence over a timeout landing in the same cycle.
        if (ack) begin
          rr_ptr   <= grant_id;
          done_cnt <= done_cnt + 16'd1;
        end else if (tmo_hit) begin
          rr_ptr <= grant_id;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end
      if (state == REQ && !ack && tmo_hit) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_b2c_req_arbiter.sv
// Scoreboard bench for b2c_req_arbiter: two requesters, four-cycle ack timeout.
module tb_b2c_req_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          clk;
  logic          rst;
  logic [1:0]    in_vld;
  logic [63:0]   in_data;
  logic [1:0]    in_rdy;
  logic          req;
  logic [31:0]   req_data;
  logic          ack;
  logic          arb_en;
  logic          err_clr;
  logic [0:0]    grant_id;
  logic          busy;
  logic [15:0]   done_cnt;
  logic          timeout_err;

  b2c_req_arbiter #(
    .NUM_REQ     (NR),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_vld      (in_vld),
    .in_data     (in_data),
    .in_rdy      (in_rdy),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .arb_en      (arb_en),
    .err_clr     (err_clr),
    .grant_id    (grant_id),
    .busy        (busy),
    .done_cnt    (done_cnt),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned id;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned m_rr;
  int unsigned m_done;

  function automatic int unsigned pick(input logic [1:0] v, input int unsigned ptr);
    for (int unsigned k = 1; k <= 2; k++) begin
      int unsigned c;
      c = (ptr + k) % 2;
      if (v[c]) return c;
    end
    return 0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int unsigned id);
    exp_t e;
    e.id   = id;
    e.data = in_data[id*32 +: 32];
    sb.push_back(e);
  endtask

  task automatic test_reset;
    rst = 1'b1; in_vld = '0; in_data = '0; ack = 1'b0; arb_en = 1'b0; err_clr = 1'b0;
    tick; tick;
    rst = 1'b0;
    m_rr = 1; m_done = 0; sb.delete();
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", req); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_checks++; if (req_data !== 32'h0) begin n_fail++; $display("FAIL reset_req_data: got %0h want 0", req_data); end
    n_checks++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    n_checks++; if (done_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_done_cnt: got %0d want 0", done_cnt); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %0b want 0", timeout_err); end
    n_checks++; if (in_rdy !== 2'b00) begin n_fail++; $display("FAIL reset_in_rdy: got %0b want 00", in_rdy); end
  endtask

  task automatic test_single;
    exp_t e;
    int unsigned w;
    arb_en = 1'b1; in_data[31:0] = 32'hA5A5_0001; in_vld = 2'b01;
    #1;
    w = pick(in_vld, m_rr);
    n_checks++; if (in_rdy !== 2'(1 << w)) begin n_fail++; $display("FAIL single_in_rdy: got %0b want %0b", in_rdy, 2'(1 << w)); end
    push_exp(w);
    tick;
    in_vld = '0;
    n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL single_req_high: got %0b want 1", req); end
    e = sb.pop_front();
    n_checks++; if (req_data !== e.data || grant_id !== 1'(e.id)) begin n_fail++; $display("FAIL single_word: got %0h/%0d want %0h/%0d", req_data, grant_id, e.data, e.id); end
    ack = 1'b1;
    tick;
    ack = 1'b0; m_done++; m_rr = w;
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL single_req_low: got %0b want 0", req); end
    n_checks++; if (done_cnt !== 16'(m_done)) begin n_fail++; $display("FAIL single_done_cnt: got %0d want %0d", done_cnt, m_done); end
    n_checks++; if (grant_id !== 1'(w)) begin n_fail++; $display("FAIL single_grant_id: got %0d want %0d", grant_id, w); end
  endtask

  task automatic test_round_robin;
    exp_t e;
    int unsigned w;
    int rdy_cnt[2];
    rdy_cnt = '{0, 0};
    in_vld = 2'b11;
    for (int t = 0; t < 6; t++) begin
      in_data = {16'hB1B1, 16'(t), 16'hB0B0, 16'(t)};
      #1;
      w = pick(2'b11, m_rr);
      n_checks++; if (in_rdy !== 2'(1 << w)) begin n_fail++; $display("FAIL rr_in_rdy t%0d: got %0b want %0b", t, in_rdy, 2'(1 << w)); end
      if (in_rdy[0]) rdy_cnt[0]++;
      if (in_rdy[1]) rdy_cnt[1]++;
      push_exp(w);
      tick;
      n_checks++; if (in_rdy !== 2'b00) begin n_fail++; $display("FAIL rr_rdy_in_req t%0d: got %0b want 00", t, in_rdy); end
      n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL rr_req t%0d: got %0b want 1", t, req); end
      e = sb.pop_front();
      n_checks++; if (req_data !== e.data || grant_id !== 1'(e.id)) begin n_fail++; $display("FAIL rr_word t%0d: got %0h/%0d want %0h/%0d", t, req_data, grant_id, e.data, e.id); end
      ack = 1'b1;
      #1;
      n_checks++; if (in_rdy !== 2'b00) begin n_fail++; $display("FAIL rr_rdy_on_ack t%0d: got %0b want 00", t, in_rdy); end
      tick;
      ack = 1'b0; m_done++; m_rr = w;
    end
    in_vld = '0;
    n_checks++; if (done_cnt !== 16'(m_done)) begin n_fail++; $display("FAIL rr_done_cnt: got %0d want %0d", done_cnt, m_done); end
    n_checks++; if (rdy_cnt[0] != 3 || rdy_cnt[1] != 3) begin n_fail++; $display("FAIL rr_rdy_pulses: got %0d/%0d want 3/3", rdy_cnt[0], rdy_cnt[1]); end
  endtask

  task automatic test_timeout;
    exp_t e;
    int unsigned w;
    int cnt;
    in_data[63:32] = 32'hBEEF_0003; in_vld = 2'b10;
    #1;
    w = pick(in_vld, m_rr);
    n_checks++; if (in_rdy !== 2'(1 << w)) begin n_fail++; $display("FAIL tmo_in_rdy: got %0b want %0b", in_rdy, 2'(1 << w)); end
    push_exp(w);
    tick;
    in_vld = '0;
    e = sb.pop_front();
    n_checks++; if (req_data !== e.data || grant_id !== 1'(e.id)) begin n_fail++; $display("FAIL tmo_word: got %0h/%0d want %0h/%0d", req_data, grant_id, e.data, e.id); end
    cnt = 0;
    for (int i = 0; i < 20 && req; i++) begin cnt++; tick; end
    m_rr = w;
    n_checks++; if (cnt != int'(TO)) begin n_fail++; $display("FAIL tmo_req_cycles: got %0d want %0d", cnt, TO); end
    n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err_set: got %0b want 1", timeout_err); end
    n_checks++; if (done_cnt !== 16'(m_done)) begin n_fail++; $display("FAIL tmo_done_cnt: got %0d want %0d", done_cnt, m_done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy: got %0b want 0", busy); end
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_err_clr: got %0b want 0", timeout_err); end
    // Second timeout with err_clr held: the set in the expiry cycle must win.
    err_clr = 1'b1; in_vld = 2'b10;
    #1;
    w = pick(in_vld, m_rr);
    n_checks++; if (in_rdy !== 2'(1 << w)) begin n_fail++; $display("FAIL tmo2_in_rdy: got %0b want %0b", in_rdy, 2'(1 << w)); end
    push_exp(w);
    tick;
    in_vld = '0;
    e = sb.pop_front();
    n_checks++; if (req_data !== e.data || grant_id !== 1'(e.id)) begin n_fail++; $display("FAIL tmo2_word: got %0h/%0d want %0h/%0d", req_data, grant_id, e.data, e.id); end
    for (int i = 0; i < 20 && req; i++) tick;
    m_rr = w;
    n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo2_set_wins: got %0b want 1", timeout_err); end
    tick;
    err_clr = 1'b0;
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo2_err_clr: got %0b want 0", timeout_err); end
  endtask

  task automatic test_ack_last;
    exp_t e;
    int unsigned w;
    in_data[31:0] = 32'h4444_0004; in_vld = 2'b01;
    #1;
    w = pick(in_vld, m_rr);
    n_checks++; if (in_rdy !== 2'(1 << w)) begin n_fail++; $display("FAIL acklast_in_rdy: got %0b want %0b", in_rdy, 2'(1 << w)); end
    push_exp(w);
    tick;
    in_vld = '0;
    e = sb.pop_front();
    n_checks++; if (req_data !== e.data || grant_id !== 1'(e.id)) begin n_fail++; $display("FAIL acklast_word: got %0h/%0d want %0h/%0d", req_data, grant_id, e.data, e.id); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL acklast_req c%0d: got %0b want 1", i + 1, req); end
      tick;
    end
    n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL acklast_req c4: got %0b want 1", req); end
    ack = 1'b1;
    tick;
    ack = 1'b0; m_done++; m_rr = w;
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL acklast_req_low: got %0b want 0", req); end
    n_checks++; if (done_cnt !== 16'(m_done)) begin n_fail++; $display("FAIL acklast_done_cnt: got %0d want %0d", done_cnt, m_done); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL acklast_timeout_err: got %0b want 0", timeout_err); end
  endtask

  task automatic test_arb_en;
    exp_t e;
    int unsigned w;
    in_vld = 2'b11; in_data = {32'h5555_0001, 32'h5555_0000}; arb_en = 1'b1;
    #1;
    w = pick(in_vld, m_rr);
    n_checks++; if (in_rdy !== 2'(1 << w)) begin n_fail++; $display("FAIL arben_in_rdy: got %0b want %0b", in_rdy, 2'(1 << w)); end
    push_exp(w);
    tick;
    arb_en = 1'b0;
    e = sb.pop_front();
    n_checks++; if (req_data !== e.data || grant_id !== 1'(e.id)) begin n_fail++; $display("FAIL arben_word: got %0h/%0d want %0h/%0d", req_data, grant_id, e.data, e.id); end
    tick;
    n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL arben_no_abort: got %0b want 1", req); end
    ack = 1'b1;
    tick;
    ack = 1'b0; m_done++; m_rr = w;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (in_rdy !== 2'b00 || req !== 1'b0) begin n_fail++; $display("FAIL arben_blocked c%0d: got rdy %0b req %0b want 00/0", i, in_rdy, req); end
      tick;
    end
    n_checks++; if (done_cnt !== 16'(m_done)) begin n_fail++; $display("FAIL arben_done_cnt: got %0d want %0d", done_cnt, m_done); end
    arb_en = 1'b1;
    #1;
    w = pick(in_vld, m_rr);
    n_checks++; if (in_rdy !== 2'(1 << w)) begin n_fail++; $display("FAIL arben_next_grant: got %0b want %0b", in_rdy, 2'(1 << w)); end
    push_exp(w);
    tick;
    in_vld = '0;
    e = sb.pop_front();
    n_checks++; if (req_data !== e.data || grant_id !== 1'(e.id)) begin n_fail++; $display("FAIL arben_word2: got %0h/%0d want %0h/%0d", req_data, grant_id, e.data, e.id); end
    ack = 1'b1;
    tick;
    ack = 1'b0; m_done++; m_rr = w;
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int unsigned w;
    in_data[63:32] = 32'h6666_0006; in_vld = 2'b10;
    #1;
    w = pick(in_vld, m_rr);
    n_checks++; if (in_rdy !== 2'(1 << w)) begin n_fail++; $display("FAIL rstmid_in_rdy: got %0b want %0b", in_rdy, 2'(1 << w)); end
    push_exp(w);
    tick;
    in_vld = '0;
    e = sb.pop_front();
    n_checks++; if (req_data !== e.data || grant_id !== 1'(e.id)) begin n_fail++; $display("FAIL rstmid_word: got %0h/%0d want %0h/%0d", req_data, grant_id, e.data, e.id); end
    tick;
    n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL rstmid_req_c2: got %0b want 1", req); end
    rst = 1'b1;
    tick;
    rst = 1'b0; ack = 1'b1;
    m_rr = 1; m_done = 0;
    n_checks++; if (req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_req_busy: got %0b/%0b want 0/0", req, busy); end
    n_checks++; if (done_cnt !== 16'h0 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_counters: got %0d/%0b want 0/0", done_cnt, timeout_err); end
    n_checks++; if (grant_id !== 1'b0 || req_data !== 32'h0) begin n_fail++; $display("FAIL rstmid_regs: got %0d/%0h want 0/0", grant_id, req_data); end
    tick;
    ack = 1'b0;
    n_checks++; if (req !== 1'b0 || done_cnt !== 16'h0) begin n_fail++; $display("FAIL rstmid_late_ack: got %0b/%0d want 0/0", req, done_cnt); end
    in_vld = 2'b11; in_data = {32'h7777_0001, 32'h7777_0000};
    #1;
    w = pick(in_vld, m_rr);
    n_checks++; if (in_rdy !== 2'(1 << w)) begin n_fail++; $display("FAIL rstmid_first_grant: got %0b want %0b", in_rdy, 2'(1 << w)); end
    push_exp(w);
    tick;
    in_vld = '0;
    e = sb.pop_front();
    n_checks++; if (req_data !== e.data || grant_id !== 1'(e.id)) begin n_fail++; $display("FAIL rstmid_word2: got %0h/%0d want %0h/%0d", req_data, grant_id, e.data, e.id); end
    ack = 1'b1;
    tick;
    ack = 1'b0; m_done++; m_rr = w;
    n_checks++; if (done_cnt !== 16'(m_done)) begin n_fail++; $display("FAIL rstmid_done_cnt: got %0d want %0d", done_cnt, m_done); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_timeout;
    test_ack_last;
    test_arb_en;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
